// File: rtl/inst_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue_if
// Description : Handshake bundle between the fetch stage, the instruction
//               fetch queue and the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_queue_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              push;
    logic [ADDR_W-1:0] push_pc;
    logic [DATA_W-1:0] push_inst;
    logic              full;
    logic              pop;
    logic              valid;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc_4;
    logic [DATA_W-1:0] out_inst;
    logic [CNT_W-1:0]  count;

    // Fetch/decode side driving the queue.
    modport master (
        output flush, push, push_pc, push_inst, pop,
        input  full, valid, out_pc, out_pc_4, out_inst, count
    );

    // The queue itself.
    modport slave (
        input  flush, push, push_pc, push_inst, pop,
        output full, valid, out_pc, out_pc_4, out_inst, count
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue
// Description : Register-based circular buffer decoupling instruction fetch
//               from decode. Head entry is presented combinationally; flush
//               discards all entries and has priority over push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    inst_fetch_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0]  c_PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  c_CNT_FULL = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic [DATA_W-1:0] r_mem_inst [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_valid;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic [ADDR_W-1:0] w_head_pc;

    // Status is decoded from the registered count only, so full/valid never
    // depend combinationally on push or pop.
    assign w_full    = (r_count == c_CNT_FULL);
    assign w_valid   = (r_count != '0);
    assign w_push_ok = bus.push & ~w_full  & ~bus.flush;
    assign w_pop_ok  = bus.pop  &  w_valid & ~bus.flush;

    // Entry storage: written at the write pointer on an accepted push.
    // Contents are not reset; only the head entry is ever observed.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_pc[r_wr_ptr]   <= bus.push_pc;
            r_mem_inst[r_wr_ptr] <= bus.push_inst;
        end
    end

    // Pointer and occupancy update; flush empties the queue and wins over
    // any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Head entry outputs; an empty queue presents a NOP at address 0.
    always_comb begin
        w_head_pc    = '0;
        bus.out_inst = '0;
        if (w_valid) begin
            w_head_pc    = r_mem_pc[r_rd_ptr];
            bus.out_inst = r_mem_inst[r_rd_ptr];
        end
    end

    assign bus.out_pc   = w_head_pc;
    assign bus.out_pc_4 = w_head_pc + c_ADDR_ONE;   // carry out is dropped
    assign bus.full     = w_full;
    assign bus.valid    = w_valid;
    assign bus.count    = r_count;
endmodule
`default_nettype wire

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: instruction-memory word-address width, equal to `IM_ADDR_BIT`.
REQ-002 SHALL have parameter DATA_W, default 32: instruction width.
REQ-003 SHALL have parameter DEPTH, default 4: entry count; a power of two, at least 2.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port flush, input, 1: a redirect (load_pc asserted to the PC) is in progress; discard all queued entries.
REQ-007 SHALL have port push, input, 1: the fetch stage presents a fetched instruction this cycle.
REQ-008 SHALL have port push_pc, input, ADDR_W: word address of the pushed instruction.
REQ-009 SHALL have port push_inst, input, DATA_W: the pushed instruction word.
REQ-010 SHALL have port full, output, 1: no free entry; drives the PC enable low (PC en = !full).
REQ-011 SHALL have port pop, input, 1: decode consumes the head entry this cycle.
REQ-012 SHALL have port valid, output, 1: the head entry is present (queue not empty).
REQ-013 SHALL have port out_pc, output, ADDR_W: word address of the head entry.
REQ-014 SHALL have port out_pc_4, output, ADDR_W: out_pc + 1, wrapping modulo 2^ADDR_W.
REQ-015 SHALL have port out_inst, output, DATA_W: instruction word of the head entry.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1: number of occupied entries.

Function
REQ-017 SHALL store entries in registers as a circular buffer with a write pointer and a read pointer, each $clog2(DEPTH) bits; both wrap from DEPTH-1 to 0.
REQ-018 SHALL accept a push only when push=1, full=0 and flush=0; an accepted push writes {push_pc, push_inst} at the write pointer and advances the write pointer on the same edge.
REQ-019 SHALL drop a push presented while full=1 without changing state, even if pop=1 in the same cycle; a slot freed by a pop is usable from the next cycle.
REQ-020 SHALL accept a pop only when pop=1, valid=1 and flush=0; an accepted pop advances the read pointer.
REQ-021 SHALL ignore a pop presented while valid=0; a same-cycle push into an empty queue is still stored.
REQ-022 SHALL, on an accepted push and accepted pop in the same cycle, leave count unchanged and advance both pointers.
REQ-023 SHALL give flush priority over push and pop: at the edge, both pointers and count go to 0 and same-cycle push/pop are discarded.
REQ-024 SHALL drive full = (count == DEPTH) and valid = (count != 0), decoded from registered count with no combinational path from push or pop.
REQ-025 SHALL present the head entry combinationally from storage (zero-cycle read latency); minimum push-to-valid latency is 1 cycle.
REQ-026 SHALL force out_inst = 0 (NOP) and out_pc = 0 while valid=0; out_pc_4 then reads 1.
REQ-027 SHALL drop any carry out of bit ADDR_W-1 when computing out_pc_4 (e.g. out_pc = 2^ADDR_W-1 gives out_pc_4 = 0).
REQ-028 SHALL leave entry contents that are not pointed to unconstrained; only head-entry outputs are architecturally visible.

Reset
REQ-029 SHALL, on rst_n=0, immediately (asynchronously) clear both pointers and count to 0, so full=0, valid=0, out_inst=0, out_pc=0 and out_pc_4=1.
REQ-030 SHALL ignore push, pop and flush while rst_n=0; normal operation resumes at the first rising clk edge after rst_n=1.
REQ-031 SHALL discard in-flight entries when reset asserts mid-operation; they are not visible after reset.

Verification
REQ-032 SHALL be verified for fill/drain: push pc=0..3 with inst=0xA0..0xA3 on four cycles, no pop -> count=4 and full=1; then pop four cycles -> out_pc/out_inst read 0/0xA0 .. 3/0xA3 in order, then valid=0 and out_inst=0.
REQ-033 SHALL be verified for overflow: with the queue full, push=1 and pop=1 with push_pc=9 -> count goes 4->3, pc 9 is absent; the next cycle's push is accepted.
REQ-034 SHALL be verified for flush priority: with count=3, assert flush, push and pop together -> next cycle count=0, valid=0, and the pushed entry is absent.
REQ-035 SHALL be verified for pointer wrap: perform 10 push/pop pairs with incrementing pc -> head order is preserved across pointer wrap and count stays at 1.
REQ-036 SHALL be verified for address wrap: push pc=0x3FF with ADDR_W=10 -> out_pc_4=0x000.
REQ-037 SHALL be verified for reset mid-operation: drop rst_n between clock edges with count=2 -> valid=0 and count=0 before the next edge; after release, the first push appears at the head.
